bcd_feed_7seg: RTL and testbench
================================

// Module: bcd_feed_7seg
// PURPOSE
//  Source side of the 7-segment display interface. Takes a binary count (0..63)
//  and converts it sequentially (shift-add-3) into BCD units/tens digits. Presents
//  the digits, a registered copy of the control-FSM state, and a display enable
//  to the 7-seg scan driver. Sits between the control FSM/counter and the display
//  multiplexer.
// PARAMETERS
//  MAX_VAL  59  largest legal value; a value above it drives both digits to 4'hF
//               so the display shows "X".
// PORTS
//  clk       in   1  system clock, all logic on rising edge
//  reset     in   1  synchronous, active-high reset
//  value     in   6  binary value to display, sampled on accepted start
//  start     in   1  request conversion of value (level or pulse)
//  fsm_st    in   2  control-FSM state code (1..3), forwarded to est_maq
//  blank     in   1  1 = force display off (EN low)
//  unit      out  4  BCD units digit to display driver
//  dec       out  4  BCD tens digit to display driver
//  est_maq   out  2  registered fsm_st
//  EN        out  1  display enable to scan driver
//  busy      out  1  conversion in progress
//  done      out  1  one-cycle pulse when unit/dec update
// BEHAVIOUR
//  - Reset values: unit=0, dec=0, est_maq=0, EN=0, busy=0, done=0, FSM=IDLE, count=0.
//  - FSM states:
//    - IDLE -> CONV on start=1: latch value, clear the BCD shift register, count=0.
//    - CONV: 6 iterations, one per clk. Each iteration first adds 3 to any BCD
//      nibble >=5, then shifts {tens,units,bin} left by 1. After the 6th iteration
//      the FSM goes to DONE.
//    - DONE: register unit/dec, pulse done, return to IDLE.
//  - Latency: start sampled at edge N. New unit/dec and done=1 are visible after
//    edge N+7. done falls after edge N+8. Back-to-back starts are accepted every
//    8 cycles.
//  - busy=1 from after edge N up to and including the cycle in which done=1.
//  - start while busy is ignored; it is not queued.
//  - unit/dec hold their last value between conversions and never show
//    intermediate results.
//  - Range check on the latched value: if >MAX_VAL, DONE writes unit=dec=4'hF.
//    The conversion still takes the full 7 cycles.
//  - Widths: the internal shift register is 4+4+6 = 14 bits. The tens nibble never
//    exceeds 6 for a 6-bit input. No wrap-around.
//  - est_maq <= fsm_st every cycle (1-cycle delay), independent of the FSM.
//  - EN:
//    - set at the DONE edge of the first conversion after reset, if blank=0;
//    - cleared on the next edge whenever blank=1;
//    - re-set at the next edge after blank returns to 0, but only if a conversion
//      has completed since reset.
//  - Reset asserted mid-conversion: abort, all outputs take reset values at that
//    edge, no done pulse.
//  - Simultaneous start and reset: reset wins.
//  - Simultaneous blank and DONE: digits update, EN=0.
// TESTING
//  1. reset 2 cycles -> unit=0, dec=0, EN=0, busy=0. Then start with value=37 ->
//     after 7 edges unit=7, dec=3, done=1 for exactly one cycle, EN=1.
//  2. value=0, value=59, value=9 -> (0,0), (9,5), (9,0). Check busy is high for
//     exactly 8 cycles each time.
//  3. value=60, then value=63 -> unit=dec=4'hF. Then value=12 -> unit=2, dec=1.
//  4. start held high continuously with value stepping -> one conversion per
//     8 cycles; start pulses during busy are ignored and the digits never glitch.
//  5. reset at the 3rd CONV cycle of value=45 -> outputs at reset values, no done.
//     Next start of 45 -> unit=5, dec=4.
//  6. blank=1 -> EN=0 on the next edge, digits unchanged. blank=0 -> EN=1 on the
//     next edge. fsm_st 1->2->3 -> est_maq follows one cycle later.

Source files
------------

// File: rtl/bcd_feed_7seg_if.sv
// Bus between the count/control side and the 7-segment scan driver.
// The master drives the request side; bcd_feed_7seg is the slave.
interface bcd_feed_7seg_if;
  logic [5:0] value;
  logic       start;
  logic [1:0] fsm_st;
  logic       blank;
  logic [3:0] unit;
  logic [3:0] dec;
  logic [1:0] est_maq;
  logic       EN;
  logic       busy;
  logic       done;

  modport master (
    output value, start, fsm_st, blank,
    input  unit, dec, est_maq, EN, busy, done
  );

  modport slave (
    input  value, start, fsm_st, blank,
    output unit, dec, est_maq, EN, busy, done
  );
endinterface

// File: rtl/bcd_feed_7seg.sv
// Sequential shift-add-3 binary-to-BCD converter feeding the 7-segment scan driver.
// Digits only change on the DONE edge; out-of-range values show as 4'hF on both digits.
module bcd_feed_7seg #(
  parameter int unsigned MAX_VAL = 59
) (
  input  logic            clk,
  input  logic            reset,
  bcd_feed_7seg_if.slave  bus
);

  localparam int unsigned BIN_W = 6;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned SH_W  = 2 * DIG_W + BIN_W;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned ITERS = BIN_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [SH_W-1:0]  r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic [BIN_W-1:0] r_val;
  logic [DIG_W-1:0] r_unit;
  logic [DIG_W-1:0] r_dec;
  logic [1:0]       r_est_maq;
  logic             r_en;
  logic             r_busy;
  logic             r_done;
  logic             r_seen;

  logic [DIG_W-1:0] w_tens_adj;
  logic [DIG_W-1:0] w_units_adj;
  logic [SH_W-1:0]  w_sh_next;
  logic             w_last;
  logic             w_over;

  // One double-dabble step: correct nibbles >= 5, then shift {tens,units,bin} left.
  always_comb begin
    w_tens_adj  = r_sh[SH_W-1 -: DIG_W];
    w_units_adj = r_sh[BIN_W +: DIG_W];
    if (w_tens_adj >= DIG_W'(5))  w_tens_adj  = w_tens_adj + DIG_W'(3);
    if (w_units_adj >= DIG_W'(5)) w_units_adj = w_units_adj + DIG_W'(3);
    w_sh_next = {w_tens_adj, w_units_adj, r_sh[BIN_W-1:0]} << 1;
    w_last    = (r_cnt == CNT_W'(ITERS - 1));
    w_over    = (r_val > BIN_W'(MAX_VAL));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sh      <= '0;
      r_cnt     <= '0;
      r_val     <= '0;
      r_unit    <= '0;
      r_dec     <= '0;
      r_est_maq <= '0;
      r_en      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_seen    <= 1'b0;
    end else begin
      r_est_maq <= bus.fsm_st;
      r_done    <= 1'b0;
      // Display is enabled only once a conversion has landed, and blank always wins.
      r_en      <= !bus.blank && (r_seen || (r_state == S_DONE));
      case (r_state)
        S_IDLE: begin
          r_busy <= bus.start;
          if (bus.start) begin
            r_val   <= bus.value;
            r_sh    <= {{(2*DIG_W){1'b0}}, bus.value};
            r_cnt   <= '0;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_busy <= 1'b1;
          r_sh   <= w_sh_next;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b1;
          r_done  <= 1'b1;
          r_seen  <= 1'b1;
          r_state <= S_IDLE;
          if (w_over) begin
            r_unit <= '1;
            r_dec  <= '1;
          end else begin
            r_unit <= r_sh[BIN_W +: DIG_W];
            r_dec  <= r_sh[SH_W-1 -: DIG_W];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.unit    = r_unit;
  assign bus.dec     = r_dec;
  assign bus.est_maq = r_est_maq;
  assign bus.EN      = r_en;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_bcd_feed_7seg.sv
// Self-checking bench for bcd_feed_7seg: directed vector table, hand-written
// corner sequences, and a randomized run against a cycle-level reference model.
module tb_bcd_feed_7seg;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_feed_7seg_if bus();

  bcd_feed_7seg #(.MAX_VAL(59)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [5:0] value;
    logic [3:0] exp_unit;
    logic [3:0] exp_dec;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_unit(input int v);
    return (v > 59) ? 15 : v % 10;
  endfunction

  function automatic int ref_dec(input int v);
    return (v > 59) ? 15 : v / 10;
  endfunction

  // Issue one start pulse and check latency, busy width, digits and EN.
  task automatic run_conv(input logic [5:0] v, input logic [3:0] eu, input logic [3:0] ed);
    int   edges;
    int   busy_cnt;
    bit   glitch;
    bit   seen_done;
    logic [3:0] pu, pd;
    pu = bus.unit;
    pd = bus.dec;
    bus.value = v;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    busy_cnt  = bus.busy ? 1 : 0;
    edges     = 0;
    glitch    = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12 && !seen_done; i++) begin
      tick();
      edges++;
      if (bus.busy) busy_cnt++;
      if (bus.done) seen_done = 1'b1;
      else if (bus.unit !== pu || bus.dec !== pd) glitch = 1'b1;
    end
    chk("done_seen", 32'(seen_done), 1);
    chk("latency", 32'(edges), 7);
    chk("no_glitch", 32'(glitch), 0);
    chk("unit", 32'(bus.unit), 32'(eu));
    chk("dec", 32'(bus.dec), 32'(ed));
    chk("en_after_done", 32'(bus.EN), 1);
    tick();
    chk("done_one_cycle", 32'(bus.done), 0);
    chk("busy_low_after", 32'(bus.busy), 0);
    chk("busy_width", 32'(busy_cnt), 8);
    chk("unit_hold", 32'(bus.unit), 32'(eu));
  endtask

  initial begin
    bus.value  = '0;
    bus.start  = 1'b0;
    bus.fsm_st = 2'd0;
    bus.blank  = 1'b0;
    reset      = 1'b1;

    vecs[0] = '{6'd37, 4'd7,  4'd3};
    vecs[1] = '{6'd0,  4'd0,  4'd0};
    vecs[2] = '{6'd59, 4'd9,  4'd5};
    vecs[3] = '{6'd9,  4'd9,  4'd0};
    vecs[4] = '{6'd60, 4'hF,  4'hF};
    vecs[5] = '{6'd63, 4'hF,  4'hF};
    vecs[6] = '{6'd12, 4'd2,  4'd1};

    // Reset state
    tick();
    bus.fsm_st = 2'd1;
    tick();
    chk("rst_unit", 32'(bus.unit), 0);
    chk("rst_dec", 32'(bus.dec), 0);
    chk("rst_en", 32'(bus.EN), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_est_maq", 32'(bus.est_maq), 0);

    // Simultaneous start and reset: reset wins
    bus.start = 1'b1;
    bus.value = 6'd21;
    tick();
    chk("rst_start_busy", 32'(bus.busy), 0);
    reset     = 1'b0;
    bus.start = 1'b0;
    tick();
    chk("rst_start_busy2", 32'(bus.busy), 0);
    chk("en_before_conv", 32'(bus.EN), 0);

    foreach (vecs[i]) run_conv(vecs[i].value, vecs[i].exp_unit, vecs[i].exp_dec);

    // Reset during the third CONV cycle of 45
    bus.value = 6'd45;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_unit", 32'(bus.unit), 0);
    chk("abort_dec", 32'(bus.dec), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_en", 32'(bus.EN), 0);
    begin
      bit any_done;
      any_done = bus.done;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (bus.done) any_done = 1'b1;
      end
      chk("abort_no_done", 32'(any_done), 0);
    end
    run_conv(6'd45, 4'd5, 4'd4);

    // Blank control and est_maq forwarding
    bus.blank = 1'b1;
    tick();
    chk("blank_en", 32'(bus.EN), 0);
    chk("blank_unit", 32'(bus.unit), 5);
    chk("blank_dec", 32'(bus.dec), 4);
    bus.blank = 1'b0;
    tick();
    chk("unblank_en", 32'(bus.EN), 1);
    for (int s = 1; s <= 3; s++) begin
      bus.fsm_st = 2'(s);
      tick();
      chk("est_maq", 32'(bus.est_maq), 32'(s));
    end

    // Randomized run from reset against the reference model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    begin
      int   free_edge, due;
      int   m_unit, m_dec, p_unit, p_dec;
      bit   m_seen, m_en, m_done, m_busy;
      logic [1:0] m_est;
      free_edge = 0;
      due       = -1;
      m_unit    = 0;
      m_dec     = 0;
      p_unit    = 0;
      p_dec     = 0;
      m_seen    = 1'b0;
      for (int e = 0; e < 400; e++) begin
        bus.value  = 6'($urandom % 64);
        bus.start  = (e < 48) ? 1'b1 : ($urandom % 4 == 0);
        bus.blank  = (e >= 48) && ($urandom % 8 == 0);
        bus.fsm_st = 2'($urandom_range(1, 3));
        if (e >= free_edge && bus.start) begin
          due       = e + 7;
          free_edge = e + 8;
          p_unit    = ref_unit(int'(bus.value));
          p_dec     = ref_dec(int'(bus.value));
        end
        m_done = (e == due);
        if (m_done) begin
          m_unit = p_unit;
          m_dec  = p_dec;
        end
        m_en   = !bus.blank && (m_seen || m_done);
        m_seen = m_seen || m_done;
        m_busy = (e < free_edge);
        m_est  = bus.fsm_st;
        tick();
        chk("rnd_unit", 32'(bus.unit), 32'(m_unit));
        chk("rnd_dec", 32'(bus.dec), 32'(m_dec));
        chk("rnd_done", 32'(bus.done), 32'(m_done));
        chk("rnd_busy", 32'(bus.busy), 32'(m_busy));
        chk("rnd_en", 32'(bus.EN), 32'(m_en));
        chk("rnd_est_maq", 32'(bus.est_maq), 32'(m_est));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
